colormap_arbiter: RTL and testbench

Shares one single-cycle colormap LUT between `N_CORES` Mandelbrot iteration engines. The block round-robin-arbitrates core results (iteration count plus pixel address), issues one lookup per cycle to the LUT, re-pairs each returned RGB565 word with its address, and buffers it toward the framebuffer write port under valid/ready backpressure. It sits between the compute core array and the framebuffer writer.

---
 rtl/colormap_arbiter.sv | 151 +++++++++++++++
 tb/tb_colormap_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/colormap_arbiter.sv
// Round-robin arbiter sharing one colormap LUT between N_CORES engines, with a 2-entry {addr,rgb} output FIFO.
// Optional frame pixel counter / frame_done pulse enabled by defining COLORMAP_ARB_FRAME_EN.
module colormap_arbiter #(
  parameter int N_CORES      = 4,
  parameter int ITER_W       = 16,
  parameter int ADDR_W       = 17,
  parameter int FRAME_PIXELS = 76800
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_CORES-1:0]          core_valid,
  output logic [N_CORES-1:0]          core_ready,
  input  logic [N_CORES*ITER_W-1:0]   core_iter,
  input  logic [N_CORES*ADDR_W-1:0]   core_addr,
  output logic [ITER_W-1:0]           lut_iter,
  output logic                        lut_valid,
  input  logic [15:0]                 lut_rgb,
  output logic                        fb_valid,
  input  logic                        fb_ready,
  output logic [ADDR_W-1:0]           fb_addr,
  output logic [15:0]                 fb_data,
  output logic                        busy,
  output logic                        frame_done
);

  localparam int LW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  logic               inflight;
  logic [ADDR_W-1:0]  addr_d1;
  logic [1:0]         occ;
  logic [LW-1:0]      last;
  logic [ADDR_W-1:0]  head_addr, tail_addr;
  logic [15:0]        head_rgb, tail_rgb;

  logic               pop, push, can_issue, hs, found;
  logic [2:0]         load;
  logic [LW-1:0]      gidx;
  logic [N_CORES-1:0] grant;
  logic [ITER_W-1:0]  sel_iter;
  logic [ADDR_W-1:0]  sel_addr;
  int                 idx;

  assign fb_valid = (occ != 2'd0);
  assign pop      = fb_valid & fb_ready;
  assign push     = inflight;
  assign load     = {1'b0, occ} + {2'b00, inflight};
  // rst_n gating keeps core_ready/lut outputs at 0 while reset is asserted
  assign can_issue = rst_n & (load < (pop ? 3'd3 : 3'd2));

  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N_CORES; k++) begin
      idx = (int'(last) + k) % N_CORES;
      if (!found && core_valid[idx]) begin
        found      = 1'b1;
        gidx       = LW'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_iter = '0;
    sel_addr = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (grant[i]) begin
        sel_iter = core_iter[i*ITER_W +: ITER_W];
        sel_addr = core_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign hs         = can_issue & found;
  assign core_ready = grant & {N_CORES{can_issue}};
  assign lut_valid  = hs;
  assign lut_iter   = hs ? sel_iter : '0;
  assign fb_addr    = head_addr;
  assign fb_data    = head_rgb;
  assign busy       = inflight | fb_valid;

  // Capture keys on our own inflight bit: the LUT's valid_out has no reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight  <= 1'b0;
      addr_d1   <= '0;
      last      <= LW'(N_CORES - 1);
      occ       <= 2'd0;
      head_addr <= '0;
      head_rgb  <= '0;
      tail_addr <= '0;
      tail_rgb  <= '0;
    end else begin
      inflight <= hs;
      if (hs) begin
        addr_d1 <= sel_addr;
        last    <= gidx;
      end
      occ <= occ + {1'b0, push} - {1'b0, pop};
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            head_addr <= addr_d1;
            head_rgb  <= lut_rgb;
          end else begin
            tail_addr <= addr_d1;
            tail_rgb  <= lut_rgb;
          end
        end
        2'b01: begin
          head_addr <= tail_addr;
          head_rgb  <= tail_rgb;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            head_addr <= addr_d1;
            head_rgb  <= lut_rgb;
          end else begin
            head_addr <= tail_addr;
            head_rgb  <= tail_rgb;
            tail_addr <= addr_d1;
            tail_rgb  <= lut_rgb;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef COLORMAP_ARB_FRAME_EN
  localparam int FW = $clog2(FRAME_PIXELS);
  logic [FW-1:0] frame_cnt;
  logic          frame_last;

  assign frame_last = (frame_cnt == FW'(FRAME_PIXELS - 1));
  assign frame_done = pop & frame_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (pop) begin
      frame_cnt <= frame_last ? '0 : frame_cnt + 1'b1;
    end
  end
`else
  assign frame_done = 1'b0;
`endif

endmodule

// File: tb/tb_colormap_arbiter.sv
// Self-checking bench for colormap_arbiter: LUT model, expected-word scoreboard, directed arbitration cases.
// Frame pulse expectations follow COLORMAP_ARB_FRAME_EN (bench uses FRAME_PIXELS=8).
module tb_colormap_arbiter;

  localparam int N        = 4;
  localparam int IW       = 16;
  localparam int AW       = 17;
  localparam int FP       = 8;
  localparam int MAX_ITER = 1000;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [15:0]   d;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    core_valid = '0;
  logic [N-1:0]    core_ready;
  logic [N*IW-1:0] core_iter;
  logic [N*AW-1:0] core_addr;
  logic [IW-1:0]   lut_iter;
  logic            lut_valid;
  logic [15:0]     lut_rgb;
  logic            fb_valid;
  logic            fb_ready = 1'b0;
  logic [AW-1:0]   fb_addr;
  logic [15:0]     fb_data;
  logic            busy;
  logic            frame_done;

  logic [IW-1:0]   cur_iter [N];
  logic [AW-1:0]   cur_addr [N];
  exp_t            sbq [$];
  int              n_chk = 0;
  int              n_fail = 0;
  int              pops = 0;
  int              exp_last = N - 1;

  always #5 clk = ~clk;

  colormap_arbiter #(
    .N_CORES(N), .ITER_W(IW), .ADDR_W(AW), .FRAME_PIXELS(FP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .core_valid(core_valid), .core_ready(core_ready),
    .core_iter(core_iter), .core_addr(core_addr),
    .lut_iter(lut_iter), .lut_valid(lut_valid), .lut_rgb(lut_rgb),
    .fb_valid(fb_valid), .fb_ready(fb_ready),
    .fb_addr(fb_addr), .fb_data(fb_data),
    .busy(busy), .frame_done(frame_done)
  );

  function automatic logic [15:0] palette(input logic [IW-1:0] it);
    if (int'(it) >= MAX_ITER) return 16'h0000;
    return {it[4:0] + 5'd1, it[10:5] ^ 6'h15, it[4:0] ^ 5'h0A};
  endfunction

  // Registered LUT without reset, one-cycle latency
  always @(posedge clk) lut_rgb <= palette(lut_iter);

  always_comb begin
    core_iter = '0;
    core_addr = '0;
    for (int i = 0; i < N; i++) begin
      core_iter[i*IW +: IW] = cur_iter[i];
      core_addr[i*AW +: AW] = cur_addr[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic new_data(input int g);
    cur_iter[g] = IW'($urandom_range(0, MAX_ITER - 1));
    cur_addr[g] = AW'($urandom_range(0, 76799));
  endtask

  // Output monitor: compares popped words against the scoreboard and checks frame_done
  always @(negedge clk) begin
    if (rst_n) begin
      logic fd_exp;
      fd_exp = 1'b0;
      if (fb_valid && fb_ready) begin
`ifdef COLORMAP_ARB_FRAME_EN
        fd_exp = ((pops % FP) == FP - 1);
`endif
        chk("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) begin
          exp_t e;
          e = sbq.pop_front();
          chk("fb_addr", 32'(fb_addr), 32'(e.a));
          chk("fb_data", 32'(fb_data), 32'(e.d));
        end
        pops++;
      end
      chk("frame_done", 32'(frame_done), 32'(fd_exp));
    end
  end

  // Handshake with a single known winner g; inputs already driven
  task automatic issue_one(input int g);
    @(negedge clk);
    chk("grant", 32'(core_ready), 32'(1 << g));
    chk("lut_valid", 32'(lut_valid), 32'd1);
    chk("lut_iter", 32'(lut_iter), 32'(cur_iter[g]));
    sbq.push_back({cur_addr[g], palette(cur_iter[g])});
    exp_last = g;
    step();
    core_valid = '0;
    new_data(g);
  endtask

  // All cores valid: winner rotates after the previous grant
  task automatic issue_all(input int n, input bit chk_stream);
    for (int c = 0; c < n; c++) begin
      int g;
      g = (exp_last + 1) % N;
      @(negedge clk);
      chk("rr_grant", 32'(core_ready), 32'(1 << g));
      chk("rr_lut_iter", 32'(lut_iter), 32'(cur_iter[g]));
      if (chk_stream && c >= 2) chk("stream_valid", 32'(fb_valid), 32'd1);
      sbq.push_back({cur_addr[g], palette(cur_iter[g])});
      exp_last = g;
      step();
      new_data(g);
    end
  endtask

  task automatic drain();
    core_valid = '0;
    fb_ready   = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (!busy && sbq.size() == 0) break;
    end
    @(negedge clk);
    chk("drain_busy", 32'(busy), 32'd0);
    chk("drain_sb", 32'(sbq.size()), 32'd0);
    step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(core_ready), 32'd0);
    chk({tag, "_lut_valid"}, 32'(lut_valid), 32'd0);
    chk({tag, "_lut_iter"}, 32'(lut_iter), 32'd0);
    chk({tag, "_fb_valid"}, 32'(fb_valid), 32'd0);
    chk({tag, "_fb_addr"}, 32'(fb_addr), 32'd0);
    chk({tag, "_fb_data"}, 32'(fb_data), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) new_data(i);

    // Reset state, with requests pending to prove gating
    core_valid = '1;
    fb_ready   = 1'b1;
    repeat (2) step();
    chk_all_zero("reset");
    core_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single request from core 2
    cur_iter[2] = 16'd5;
    cur_addr[2] = 17'h00010;
    core_valid  = 4'b0100;
    issue_one(2);
    @(negedge clk);
    chk("lat_c1_valid", 32'(fb_valid), 32'd0);
    chk("lat_c1_busy", 32'(busy), 32'd1);
    step();
    @(negedge clk);
    chk("lat_c2_valid", 32'(fb_valid), 32'd1);
    chk("lat_c2_data", 32'(fb_data), 32'(palette(16'd5)));
    step();
    drain();

    // All cores streaming at full rate
    core_valid = '1;
    fb_ready   = 1'b1;
    issue_all(12, 1'b1);
    drain();

    // Backpressure: two handshakes, then stalled until first pop
    core_valid = '1;
    fb_ready   = 1'b0;
    issue_all(2, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_ready", 32'(core_ready), 32'd0);
      if (c > 0) chk("bp_fb_valid", 32'(fb_valid), 32'd1);
      step();
    end
    fb_ready = 1'b1;
    issue_all(6, 1'b0);
    drain();

    // Reset with a word buffered and a lookup in flight
    core_valid = '1;
    fb_ready   = 1'b0;
    issue_all(2, 1'b0);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    core_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    sbq.delete();
    pops     = 0;
    exp_last = N - 1;
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    core_valid = '1;
    fb_ready   = 1'b1;
    issue_all(6, 1'b0);
    drain();

    // Interior point: max iteration maps to black
    cur_iter[1] = 16'(MAX_ITER);
    cur_addr[1] = 17'h1ABCD;
    core_valid  = 4'b0010;
    issue_one(1);
    step();
    @(negedge clk);
    chk("interior_valid", 32'(fb_valid), 32'd1);
    chk("interior_data", 32'(fb_data), 32'h0000);
    chk("interior_addr", 32'(fb_addr), 32'h1ABCD);
    step();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
